// File: rtl/spram_ctrl_pkg.sv
// Shared types for the single-port RAM access controller.
package spram_ctrl_pkg;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StIdle = 2'd1,
    StRd   = 2'd2,
    StResp = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/spram_access_ctrl.sv
// Initiator for an external single-port RAM: clears it after reset, then turns a
// valid/ready request stream into RAM cycles and returns read data on a response channel.
module spram_access_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth    = 6,
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned Depth        = 64,
  parameter bit          ClearOnReset = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 init_done_o,
  output logic [DataWidth-1:0] ram_data_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic                 ram_we_o,
  input  logic [DataWidth-1:0] ram_q_i
);

  // One extra bit so Depth == 2**AddrWidth still compares correctly.
  localparam logic [AddrWidth:0]   DepthW     = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(Depth - 1);
  localparam ctrl_state_e          ResetState = ClearOnReset ? StInit : StIdle;

  ctrl_state_e          state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 init_done_q, init_done_d;

  function automatic logic in_range(input logic [AddrWidth-1:0] addr);
    return {1'b0, addr} < DepthW;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ResetState;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= !ClearOnReset;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    init_done_d = init_done_q;
    req_ready_o = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = req_addr_i;
    ram_data_o  = req_wdata_i;

    unique case (state_q)
      StInit: begin
        ram_we_o   = 1'b1;
        ram_addr_o = cnt_q;
        ram_data_o = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          cnt_d       = '0;
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (req_we_i) begin
            // Out-of-range writes are dropped without any response.
            ram_we_o = in_range(req_addr_i);
          end else begin
            rd_addr_d = req_addr_i;
            state_d   = StRd;
          end
        end
      end
      StRd: begin
        ram_addr_o = rd_addr_q;
        if (in_range(rd_addr_q)) begin
          rsp_data_d = ram_q_i;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = ResetState;
    endcase
  end

  assign rsp_valid_o = (state_q == StResp);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign init_done_o = init_done_q;

endmodule
